mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - MEM pipeline stage between the EX/MEM register and the MEMORY data port; owns the MEM/WB register.
// - Converts LB/LBU/LH/LHU/LW/SB/SH/SW into word-only memory accesses:
//   - loads: lane select plus sign or zero extension;
//   - sub-word stores: read-modify-write;
//   - misalignment and bounds faults are reported to WB.
// - Non-memory ops pass alu_result through with the same latency.
// PARAMETERS
// - CHECK_BOUNDS  1  1: an address outside [`stack_size_lo, `stack_size_hi] raises addr_err
// - RESET_PC_TAG  0  reset value of wb_bad_addr (debug visibility only)
// PORTS
// - clk             in   1   stage clock; all state updates on posedge
// - rst_n           in   1   asynchronous, active-low reset
// - ex_valid        in   1   EX/MEM holds a valid op
// - ex_mem_op       in   4   `MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW
// - ex_addr         in   32  byte address; also the alu_result for MEM_NONE
// - ex_store_data   in   32  rt value; the low byte or low half is used for SB/SH
// - ex_rd           in   5   destination register
// - ex_reg_write    in   1   op writes rd
// - stall_o         out  1   1 = EX/MEM must hold; equals ~in_ready
// - mem_addr        out  32  word-aligned byte address to the data port (registered)
// - mem_write       out  1   write strobe, level-sensitive, registered
// - mem_write_data  out  32  registered write word
// - mem_read_data   in   32  combinational read word for mem_addr
// - wb_valid        out  1   MEM/WB holds a retired op
// - wb_rd           out  5   destination register
// - wb_reg_write    out  1   write rd; forced 0 on addr_err
// - wb_data         out  32  load result or passed-through alu_result
// - wb_addr_err     out  1   misaligned or out-of-bounds access
// - wb_bad_addr     out  32  faulting byte address
// BEHAVIOUR
// - Reset: every output is 0 except stall_o=0 and wb_bad_addr=RESET_PC_TAG; state=IDLE.
// - FSM IDLE -> ACCESS -> (MERGE) -> IDLE or ACCESS.
// - An op is accepted on a posedge with ex_valid && in_ready. It is captured into the req register and state goes to ACCESS.
// - in_ready = (state==IDLE) || (state==ACCESS && req not SB/SH) || (state==MERGE).
// - ACCESS: mem_addr = {req_addr[31:2],2'b00}. Action by req op:
//   - LB/LBU/LH/LHU/LW: wb_data = extended lane of mem_read_data at the end of ACCESS.
//   - SW: mem_write=1 and mem_write_data=req_data for exactly this cycle.
//   - SB/SH: read only; the merged word is registered; next state is MERGE.
//   - MEM_NONE: wb_data = req_addr.
// - MERGE: mem_write=1, with mem_addr and the merged word held stable for the whole cycle. MEM/WB is updated at the end of MERGE.
// - Latency: loads, SW and NONE take 2 edges from accept to wb_valid, at 1 op per cycle throughput. SB/SH take 3 edges and stall EX for 1 cycle.
// - Byte order is big-endian:
//   - byte offset 0 is [31:24], offset 3 is [7:0];
//   - half offset 0 is [31:16], offset 2 is [15:0].
// - LB/LH sign-extend; LBU/LHU zero-extend.
// - Faults: misalignment (LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0) or an out-of-bounds address (CHECK_BOUNDS) sets addr_err.
//   - No memory access occurs and mem_write stays 0.
//   - The op retires after ACCESS with wb_addr_err=1, wb_bad_addr=req_addr and wb_reg_write=0.
// - wb_valid=0 whenever no op retires on that edge. MEM/WB fields other than wb_valid hold their last values.
// - mem_write is never asserted in IDLE, and is never asserted on two consecutive cycles for the same SB/SH.
// - Reset mid-op (for example during MERGE) is immediate. The pending write is dropped, mem_write falls to 0, and memory keeps its old contents.
// STRUCTURE
// - Shared header ManBearPig.h: `MEM_* opcode defines (4-bit: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8), FSM state defines, and `stack_size_lo/hi.
// - Sub-module load_extend: combinational unit taking (word, offset, op) and producing the 32-bit extended result.
// - The byte merge for SB/SH stays inline.
// TESTING
// - LW 0x100 with mem[0x100]=0xDEADBEEF -> mem_write=0 throughout; wb_data=0xDEADBEEF two edges after accept.
// - LB 0x101 and LBU 0x101, same word -> wb_data=0xFFFFFFAD, then 0x000000AD; back-to-back with no stall.
// - SB 0x102 data 0x11, word 0xDEADBEEF -> stall_o=1 for 1 cycle; MERGE writes 0xDEAD11EF; mem_write is high for exactly 1 cycle.
// - SH 0x101 -> wb_addr_err=1, wb_bad_addr=0x101, wb_reg_write=0, mem_write never asserted.
// - SW 0x104 0xCAFEF00D followed by LW 0x104 -> LW returns 0xCAFEF00D.
// - SH 0x100 with rst_n dropped during MERGE -> all outputs 0 immediately; the word is unchanged after reset.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: opcodes, FSM encodings, stack bounds,
// the captured request payload and address-fault helpers.
package mem_access_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] MEM_NONE = 4'd0;
  localparam logic [OP_W-1:0] MEM_LB   = 4'd1;
  localparam logic [OP_W-1:0] MEM_LBU  = 4'd2;
  localparam logic [OP_W-1:0] MEM_LH   = 4'd3;
  localparam logic [OP_W-1:0] MEM_LHU  = 4'd4;
  localparam logic [OP_W-1:0] MEM_LW   = 4'd5;
  localparam logic [OP_W-1:0] MEM_SB   = 4'd6;
  localparam logic [OP_W-1:0] MEM_SH   = 4'd7;
  localparam logic [OP_W-1:0] MEM_SW   = 4'd8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_MERGE  = 2'd2;

  // Legal data window (inclusive) for memory ops
  localparam logic [XLEN-1:0] STACK_SIZE_LO = 32'h0000_0040;
  localparam logic [XLEN-1:0] STACK_SIZE_HI = 32'h0000_FFFF;

  // Request captured from EX/MEM; only the low half of rt is ever needed later
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  addr;
    logic [15:0]      store_lo;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             err;
  } mem_req_t;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_subword_store(input logic [OP_W-1:0] op);
    return (op == MEM_SB) || (op == MEM_SH);
  endfunction

  // Misalignment or out-of-window address for a memory op
  function automatic logic addr_fault(input logic [OP_W-1:0] op,
                                      input logic [XLEN-1:0] addr,
                                      input logic            check_bounds);
    logic misaligned;
    logic out_of_bounds;
    misaligned = (((op == MEM_LW) || (op == MEM_SW)) && (addr[1:0] != 2'b00)) ||
                 (((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) && addr[0]);
    out_of_bounds = check_bounds && ((addr < STACK_SIZE_LO) || (addr > STACK_SIZE_HI));
    return is_mem_op(op) && (misaligned || out_of_bounds);
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load lane extraction (big-endian) with sign/zero extension.
// Ports: word (memory word), offset (byte offset), op (load opcode),
//        result_c (extended result; word passes through for LW/other ops).
module mem_access_stage_load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant lane
  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd0:    byte_lane = word[31:24];
      2'd1:    byte_lane = word[23:16];
      2'd2:    byte_lane = word[15:8];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    result_c = word;
    case (op)
      MEM_LB:  result_c = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: result_c = {24'h0, byte_lane};
      MEM_LH:  result_c = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: result_c = {16'h0, half_lane};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns byte/half/word loads and stores into word-only
// accesses, does read-modify-write for SB/SH, reports address faults and
// owns the MEM/WB register.
// Ports: clk/rst_n; ex_* request from EX/MEM; stall_o back-pressure;
//        mem_* registered data-port controls plus combinational read data;
//        wb_* MEM/WB register contents.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter bit              CHECK_BOUNDS = 1'b1,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [OP_W-1:0]  ex_mem_op,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  output logic             stall_o,
  output logic [XLEN-1:0]  mem_addr,
  output logic             mem_write,
  output logic [XLEN-1:0]  mem_write_data,
  input  logic [XLEN-1:0]  mem_read_data,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_reg_write,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_addr_err,
  output logic [XLEN-1:0]  wb_bad_addr
);

  logic [1:0]       state_q, state_d;
  mem_req_t         req_q, req_d;
  logic [XLEN-1:0]  mem_addr_d, mem_write_data_d, wb_data_d, wb_bad_addr_d;
  logic             mem_write_d, wb_valid_d, wb_reg_write_d, wb_addr_err_d;
  logic [REG_W-1:0] wb_rd_d;
  logic             in_ready_c, accept_c, ex_err_c;
  logic [XLEN-1:0]  load_word_c, merge_word_c;

  mem_access_stage_load_extend u_load_extend (
    .word     (mem_read_data),
    .offset   (req_q.addr[1:0]),
    .op       (req_q.op),
    .result_c (load_word_c)
  );

  // Only a pending sub-word store blocks a new request
  assign in_ready_c = (state_q == ST_IDLE) ||
                      ((state_q == ST_ACCESS) && !is_subword_store(req_q.op)) ||
                      (state_q == ST_MERGE);
  assign accept_c   = ex_valid && in_ready_c;
  assign ex_err_c   = addr_fault(ex_mem_op, ex_addr, CHECK_BOUNDS);
  assign stall_o    = !in_ready_c;

  // Byte/half merge of the store data into the word read during ACCESS
  always_comb begin
    merge_word_c = mem_read_data;
    if (req_q.op == MEM_SB) begin
      case (req_q.addr[1:0])
        2'd0:    merge_word_c[31:24] = req_q.store_lo[7:0];
        2'd1:    merge_word_c[23:16] = req_q.store_lo[7:0];
        2'd2:    merge_word_c[15:8]  = req_q.store_lo[7:0];
        default: merge_word_c[7:0]   = req_q.store_lo[7:0];
      endcase
    end else if (req_q.addr[1]) begin
      merge_word_c[15:0]  = req_q.store_lo;
    end else begin
      merge_word_c[31:16] = req_q.store_lo;
    end
  end

  // Next-state and next-register values
  always_comb begin
    logic retire;
    state_d          = state_q;
    req_d            = req_q;
    mem_addr_d       = mem_addr;
    mem_write_d      = 1'b0;
    mem_write_data_d = mem_write_data;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd;
    wb_reg_write_d   = wb_reg_write;
    wb_data_d        = wb_data;
    wb_addr_err_d    = wb_addr_err;
    wb_bad_addr_d    = wb_bad_addr;
    retire           = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_ACCESS: begin
        if (is_subword_store(req_q.op) && !req_q.err) begin
          state_d          = ST_MERGE;
          mem_write_d      = 1'b1;
          mem_write_data_d = merge_word_c;
        end else begin
          state_d = ST_IDLE;
          retire  = 1'b1;
        end
      end
      ST_MERGE: begin
        state_d = ST_IDLE;
        retire  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (retire) begin
      wb_valid_d     = 1'b1;
      wb_rd_d        = req_q.rd;
      wb_reg_write_d = req_q.reg_write && !req_q.err;
      wb_addr_err_d  = req_q.err;
      if (req_q.err) begin
        wb_bad_addr_d = req_q.addr;
      end else if (is_load(req_q.op) && (state_q == ST_ACCESS)) begin
        wb_data_d = load_word_c;
      end else if (!is_mem_op(req_q.op)) begin
        wb_data_d = req_q.addr;
      end
    end

    if (accept_c) begin
      state_d         = ST_ACCESS;
      req_d.op        = ex_mem_op;
      req_d.addr      = ex_addr;
      req_d.store_lo  = ex_store_data[15:0];
      req_d.rd        = ex_rd;
      req_d.reg_write = ex_reg_write;
      req_d.err       = ex_err_c;
      mem_addr_d      = {ex_addr[31:2], 2'b00};
      // SW writes during its own ACCESS cycle
      if ((ex_mem_op == MEM_SW) && !ex_err_c) begin
        mem_write_d      = 1'b1;
        mem_write_data_d = ex_store_data;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      mem_addr       <= '0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_reg_write   <= 1'b0;
      wb_data        <= '0;
      wb_addr_err    <= 1'b0;
      wb_bad_addr    <= RESET_PC_TAG;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      mem_addr       <= mem_addr_d;
      mem_write      <= mem_write_d;
      mem_write_data <= mem_write_data_d;
      wb_valid       <= wb_valid_d;
      wb_rd          <= wb_rd_d;
      wb_reg_write   <= wb_reg_write_d;
      wb_data        <= wb_data_d;
      wb_addr_err    <= wb_addr_err_d;
      wb_bad_addr    <= wb_bad_addr_d;
    end
  end

endmodule
